// File: rtl/noc_credit_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_credit_receiver                                                      |
// | Credit-based link receiver: flit FIFO, credit return and framing check.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module noc_credit_receiver #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_is_tail,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  overflow_err,
  output logic                  framing_err
);

  localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [ENTRY_W-1:0]    r_mem [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [0:0]            r_state;
  logic [DEST_WIDTH-1:0] r_pkt_dest;
  logic                  r_credit;
  logic                  r_overflow;
  logic                  r_framing;

  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_head;

  // A full FIFO still accepts a flit when the head leaves on the same edge.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_valid & out_ready;
  assign w_push  = send_in & (~w_full | w_pop);
  assign w_drop  = send_in & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  // Head fields are forced to zero when empty so reset leaves clean outputs.
  assign out_valid    = w_valid;
  assign out_data     = w_valid ? w_head[ENTRY_W-1 -: FLIT_WIDTH] : '0;
  assign out_dest     = w_valid ? w_head[DEST_WIDTH:1] : '0;
  assign out_is_tail  = w_valid & w_head[0];
  assign occupancy    = r_count;
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow;
  assign framing_err  = r_framing;

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {data_in, dest_in, is_tail_in};
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_credit <= w_pop;
    end
  end

  // Framing tracker advances only on flits that were actually stored.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      r_state    <= ST_IDLE;
      r_pkt_dest <= '0;
      r_overflow <= 1'b0;
      r_framing  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        case (r_state)
          ST_IDLE: begin
            if (!is_tail_in) begin
              r_state    <= ST_IN_PKT;
              r_pkt_dest <= dest_in;
            end
          end
          default: begin
            if (dest_in != r_pkt_dest) begin
              r_framing <= 1'b1;
            end
            if (is_tail_in) begin
              r_state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_noc_credit_receiver                                                   |
// | Directed self-checking bench for noc_credit_receiver (depth 2).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_noc_credit_receiver;

  logic        clk_noc = 1'b0;
  logic        rst_noc = 1'b1;
  logic [63:0] data_in = '0;
  logic [5:0]  dest_in = '0;
  logic        is_tail_in = 1'b0;
  logic        send_in = 1'b0;
  logic        credit_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [5:0]  out_dest;
  logic        out_is_tail;
  logic [1:0]  occupancy;
  logic        overflow_err;
  logic        framing_err;

  int total = 0;
  int bad = 0;

  noc_credit_receiver #(
    .FLIT_WIDTH(64), .DEST_WIDTH(6), .FLIT_BUFFER_DEPTH(2)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_is_tail(out_is_tail), .occupancy(occupancy),
    .overflow_err(overflow_err), .framing_err(framing_err)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    rst_noc = 1'b1;
    send_in = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_noc = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, credit_out, occupancy, overflow_err, framing_err, out_data, out_dest, out_is_tail} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b credit=%b occ=%0d ovf=%b frm=%b data=%h dest=%h tail=%b exp all zero",
               out_valid, credit_out, occupancy, overflow_err, framing_err, out_data, out_dest, out_is_tail);
    end
  endtask

  task automatic test_single();
    data_in = 64'hA5; dest_in = 6'h05; is_tail_in = 1'b1; send_in = 1'b1;
    step();
    send_in = 1'b0;
    total++;
    if ({out_valid, out_data, out_dest, out_is_tail, occupancy} !== {1'b1, 64'hA5, 6'h05, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL single_push got valid=%b data=%h dest=%h tail=%b occ=%0d exp 1 a5 05 1 1",
               out_valid, out_data, out_dest, out_is_tail, occupancy);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || credit_out !== 1'b0) begin
      bad++;
      $display("FAIL single_hold got valid=%b credit=%b exp 1 0", out_valid, credit_out);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (credit_out !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop got credit=%b occ=%0d valid=%b exp 1 0 0", credit_out, occupancy, out_valid);
    end
    step();
    total++;
    if (credit_out !== 1'b0) begin
      bad++;
      $display("FAIL single_credit_width got credit=%b exp 0", credit_out);
    end
  endtask

  task automatic test_overflow();
    int credits = 0;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      data_in = 64'(k); dest_in = 6'(k); is_tail_in = 1'b1; send_in = 1'b1;
      step();
    end
    send_in = 1'b0;
    total++;
    if (occupancy !== 2'd2 || overflow_err !== 1'b1 || out_data !== 64'd1) begin
      bad++;
      $display("FAIL overflow_state got occ=%0d ovf=%b head=%h exp 2 1 1", occupancy, overflow_err, out_data);
    end
    out_ready = 1'b1;
    step();
    if (credit_out) credits++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd2) begin
      bad++;
      $display("FAIL overflow_second got valid=%b data=%h exp 1 2", out_valid, out_data);
    end
    step();
    if (credit_out) credits++;
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL overflow_third_absent got valid=%b occ=%0d exp 0 0", out_valid, occupancy);
    end
    out_ready = 1'b0;
    step();
    if (credit_out) credits++;
    step();
    if (credit_out) credits++;
    total++;
    if (credits !== 2) begin
      bad++;
      $display("FAIL overflow_credits got %0d exp 2", credits);
    end
  endtask

  task automatic test_stream();
    int credits = 2;
    int sent = 0;
    int rx = 0;
    int cred_total = 0;
    int cyc = 0;
    int data_bad = 0;
    logic [63:0] exp_d;
    out_ready = 1'b1;
    while (cyc < 300 && (rx < 100 || cred_total < 100)) begin
      if (out_valid) begin
        exp_d = {32'hC0DE0000 + 32'(rx), 32'(rx * 7)};
        total++;
        if (out_data !== exp_d || out_dest !== 6'(rx)) begin
          bad++;
          data_bad++;
          if (data_bad < 5)
            $display("FAIL stream_data idx=%0d got %h/%h exp %h/%h", rx, out_data, out_dest, exp_d, 6'(rx));
        end
        rx++;
      end
      if (credits > 0 && sent < 100) begin
        data_in = {32'hC0DE0000 + 32'(sent), 32'(sent * 7)};
        dest_in = 6'(sent);
        is_tail_in = 1'b1;
        send_in = 1'b1;
        credits--;
        sent++;
      end else begin
        send_in = 1'b0;
      end
      step();
      cyc++;
      if (credit_out) begin
        credits++;
        cred_total++;
      end
    end
    send_in = 1'b0;
    out_ready = 1'b0;
    total++;
    if (rx !== 100 || cred_total !== 100) begin
      bad++;
      $display("FAIL stream_counts got rx=%0d credits=%0d exp 100 100", rx, cred_total);
    end
    total++;
    if (cyc > 103) begin
      bad++;
      $display("FAIL stream_throughput got cycles=%0d exp <=103", cyc);
    end
    total++;
    if (overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL stream_overflow got %b exp 0", overflow_err);
    end
  endtask

  task automatic test_full_simul();
    logic [63:0] q[$];
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_in = 64'h1000 + 64'(k); dest_in = 6'h01; is_tail_in = 1'b1; send_in = 1'b1;
      q.push_back(data_in);
      step();
    end
    for (int k = 2; k < 12; k++) begin
      out_ready = 1'b1;
      data_in = 64'h1000 + 64'(k); send_in = 1'b1;
      total++;
      if (out_data !== q[0]) begin
        bad++;
        $display("FAIL full_order k=%0d got %h exp %h", k, out_data, q[0]);
      end
      void'(q.pop_front());
      q.push_back(data_in);
      step();
      total++;
      if (occupancy !== 2'd2 || overflow_err !== 1'b0) begin
        bad++;
        $display("FAIL full_occ k=%0d got occ=%0d ovf=%b exp 2 0", k, occupancy, overflow_err);
      end
    end
    send_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_data !== q[0]) begin
        bad++;
        $display("FAIL full_drain k=%0d got %h exp %h", k, out_data, q[0]);
      end
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
    total++;
    if (occupancy !== 2'd0) begin
      bad++;
      $display("FAIL full_empty got occ=%0d exp 0", occupancy);
    end
  endtask

  task automatic test_framing();
    logic [5:0] dests [4] = '{6'h12, 6'h12, 6'h13, 6'h12};
    logic       frm_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = 64'h2000 + 64'(k); dest_in = dests[k]; is_tail_in = (k == 3); send_in = 1'b1;
      step();
      total++;
      if (framing_err !== frm_exp[k] || out_data !== 64'h2000 + 64'(k) || out_dest !== dests[k]) begin
        bad++;
        $display("FAIL framing_flit k=%0d got frm=%b data=%h dest=%h exp %b %h %h",
                 k, framing_err, out_data, out_dest, frm_exp[k], 64'h2000 + 64'(k), dests[k]);
      end
    end
    data_in = 64'h77; dest_in = 6'h07; is_tail_in = 1'b1;
    step();
    send_in = 1'b0;
    total++;
    if (out_data !== 64'h77 || out_is_tail !== 1'b1 || framing_err !== 1'b1) begin
      bad++;
      $display("FAIL framing_single got data=%h tail=%b frm=%b exp 77 1 1", out_data, out_is_tail, framing_err);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    data_in = 64'h3000; dest_in = 6'h20; is_tail_in = 1'b0; send_in = 1'b1;
    step();
    send_in = 1'b0;
    total++;
    if (occupancy !== 2'd1) begin
      bad++;
      $display("FAIL midreset_setup got occ=%0d exp 1", occupancy);
    end
    out_ready = 1'b1;
    #2 rst_noc = 1'b1;
    #1;
    total++;
    if ({out_valid, credit_out, occupancy, out_data, out_dest, out_is_tail} !== '0) begin
      bad++;
      $display("FAIL midreset_async got valid=%b credit=%b occ=%0d data=%h exp all zero",
               out_valid, credit_out, occupancy, out_data);
    end
    step();
    total++;
    if (credit_out !== 1'b0) begin
      bad++;
      $display("FAIL midreset_credit got %b exp 0", credit_out);
    end
    rst_noc = 1'b0;
    out_ready = 1'b0;
    data_in = 64'h3001; dest_in = 6'h21; is_tail_in = 1'b0; send_in = 1'b1;
    step();
    data_in = 64'h3002; dest_in = 6'h21; is_tail_in = 1'b1;
    step();
    send_in = 1'b0;
    total++;
    if (framing_err !== 1'b0 || occupancy !== 2'd2 || out_data !== 64'h3001) begin
      bad++;
      $display("FAIL midreset_newpkt got frm=%b occ=%0d head=%h exp 0 2 3001", framing_err, occupancy, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    do_reset();
    test_stream();
    test_full_simul();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_credit_receiver.md
# noc_credit_receiver

Receive end of the credit-based router link (data/dest/is_tail/send forward, credit backward). It accepts flits pushed by an upstream router output port, buffers them in a FLIT_BUFFER_DEPTH-entry FIFO, presents them on a valid/ready interface to the local consumer, and returns one credit per flit drained. It also tracks packet framing and flags protocol violations. It sits between a router output (or link pipeline) and a deserializer shim or endpoint, on the NoC clock.

## Interface
Parameters:
- FLIT_WIDTH, 64: flit payload width.
- DEST_WIDTH, 6: destination field width (tid concatenated with tdest).
- FLIT_BUFFER_DEPTH, 2: FIFO entries. This equals the credit count the upstream sender is initialised with. Minimum 1; any integer is legal, not restricted to powers of two.
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1): occupancy width.

Ports:
- clk_noc  in  1  NoC clock; all logic on rising edge.
- rst_noc  in  1  asynchronous, active-high reset.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid this cycle; no ready; relies on credits.
- credit_out  out  1  one-cycle pulse = one buffer entry freed.
- out_valid  out  1  head-of-FIFO flit available.
- out_ready  in  1  consumer accepts flit.
- out_data  out  FLIT_WIDTH  head flit payload.
- out_dest  out  DEST_WIDTH  head flit destination.
- out_is_tail  out  1  head flit tail marker.
- occupancy  out  CNT_WIDTH  entries currently stored.
- overflow_err  out  1  sticky: flit arrived with no free entry.
- framing_err  out  1  sticky: mid-packet dest changed.

## Operation
- Push: send_in=1 at an edge. The flit {data_in, dest_in, is_tail_in} is written if occupancy<FLIT_BUFFER_DEPTH or a pop occurs on the same edge.
- Overflow: a push with occupancy==FLIT_BUFFER_DEPTH and no same-edge pop discards the flit and sets overflow_err. FIFO contents and occupancy are unchanged.
- Pop: out_valid & out_ready at an edge removes the head entry.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Push into an empty FIFO with a same-edge pop cannot occur, because out_valid=0 when empty.
- Occupancy arithmetic: +1 on push only, −1 on pop only, unchanged on both or neither. It never exceeds FLIT_BUFFER_DEPTH and never wraps below 0.
- Read/write pointers count 0..FLIT_BUFFER_DEPTH−1 and wrap to 0 after the last entry.
- out_valid = (occupancy != 0). out_data, out_dest and out_is_tail come from the head entry and are stable while out_valid=1 and out_ready=0.
- Credit return: credit_out is registered. It is 1 in the cycle after each pop, for exactly one cycle per pop, and is never coalesced. Discarded overflow flits return no credit.
- Framing FSM, advancing on accepted pushes only:
  - IDLE, is_tail=1: stay in IDLE (single-flit packet).
  - IDLE, is_tail=0: go to IN_PKT and latch dest_in as pkt_dest.
  - IN_PKT, dest_in != pkt_dest: set framing_err; the flit is still stored.
  - IN_PKT, is_tail=1: return to IDLE.
  - IN_PKT, is_tail=0: stay in IN_PKT.
- Error flags clear only on reset.
- Reset (asynchronous, any time including mid-packet or mid-pop):
  - FIFO is emptied and state goes to IDLE.
  - out_valid=0, out_data/out_dest/out_is_tail=0, credit_out=0, occupancy=0, overflow_err=0, framing_err=0.
  - A pop in progress at reset returns no credit.
  - The upstream sender is reset by the same reset and reinitialises to FLIT_BUFFER_DEPTH credits.

## Timing
- Push at edge N gives out_valid=1 from edge N onward (registered storage, 1-cycle first-flit latency).
- Pop at edge N gives credit_out=1 during cycle N..N+1. Round trip from pop to upstream credit increment is 1 cycle plus any link pipeline delay.
- Sustained throughput: 1 flit/cycle when out_ready=1 continuously and FLIT_BUFFER_DEPTH ≥ upstream credit loop latency. With FLIT_BUFFER_DEPTH=2, a sender with 1-cycle credit loop reaches 1 flit/cycle.
- occupancy and the error flags update on the same edge as the causing event.
- No combinational path from send_in to credit_out. No combinational path from out_ready to out_valid.

## Test plan
- Reset then idle: all outputs 0. Push flit data=0xA5, dest=0x05, tail=1 at edge 1 gives out_valid=1 after edge 1. Pop at edge 3 gives credit_out=1 for one cycle after edge 3; occupancy back to 0.
- DEPTH=2, out_ready=0, push 3 flits back to back: first two stored, occupancy=2, overflow_err=1, third flit absent. Draining gives flits 1 then 2 and exactly 2 credit pulses.
- Streaming: out_ready=1, upstream credit-model sender with 2 credits, 100 flits: 1 flit/cycle sustained, order and data intact, credits returned = 100, overflow_err=0.
- Full FIFO with simultaneous push and pop: occupancy stays 2, no overflow_err, FIFO order intact; pointer wrap exercised over ≥5 passes.
- Framing: head dest=0x12 (tail=0), body dest=0x12, body dest=0x13, tail dest=0x12 gives framing_err=1 after the third flit; all 4 flits delivered; next single-flit packet with dest=0x07 raises no new error.
- Reset asserted mid-packet with occupancy=1 and out_ready=1: outputs 0 asynchronously, no credit pulse. After release, FSM is IDLE and a new head flit is accepted without framing_err.
